io_led_pwm_ctrl: RTL and testbench



---
 rtl/io_led_pwm_ctrl_pkg.sv | 18 +
 rtl/io_led_channel.sv | 31 +++
 rtl/io_led_pwm_ctrl.sv | 137 +++++++++++++
 tb/tb_io_led_pwm_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_led_pwm_ctrl_pkg.sv
// Shared definitions for the LED PWM peripheral: register word offsets
// and per-channel mode encodings.
package io_led_pwm_ctrl_pkg;

  localparam logic [4:0] OFS_LED_EN = 5'd0;
  localparam logic [4:0] OFS_MODE   = 5'd1;
  localparam logic [4:0] OFS_BLINK  = 5'd2;
  localparam logic [4:0] OFS_STATUS = 5'd3;
  localparam logic [4:0] OFS_DUTY0  = 5'd4;

  // Encoding 2'b11 is not listed; channels treat it like static.
  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10
  } led_mode_e;

endpackage

// File: rtl/io_led_channel.sv
// One LED channel: selects static, blink or PWM drive for a single output.
// PWM is on while the shared counter is below the duty value; an all-ones
// duty forces the output fully on so there is no gap at counter wrap.
module io_led_channel
  import io_led_pwm_ctrl_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                blink_phase,
  output logic                led
);

  logic pwm_on;

  assign pwm_on = (duty == {PWM_BITS{1'b1}}) || (pwm_cnt < duty);

  // Mode mux; unlisted encodings fall back to plain enable.
  always_comb begin
    led = en;
    case (mode)
      MODE_BLINK: led = en & blink_phase;
      MODE_PWM:   led = en & pwm_on;
      default:    led = en;
    endcase
  end

endmodule

// File: rtl/io_led_pwm_ctrl.sv
// Memory-mapped multi-channel LED controller with static, blink and PWM
// modes and full register read-back. Holds the register file, the blink
// prescaler and the free-running PWM counter; per-channel muxing lives in
// io_led_channel. Define LEDS_ACTIVE_LOW_EN for inverted LED drive.
module io_led_pwm_ctrl
  import io_led_pwm_ctrl_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESC_W  = 24
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_sel,
  input  logic [4:0]        i_addr,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic [N_LEDS-1:0] o_leds
);

  logic [N_LEDS-1:0]   led_en;
  logic [2*N_LEDS-1:0] mode;
  logic [PRESC_W-1:0]  blink_period;
  logic [PWM_BITS-1:0] duty [N_LEDS];
  logic [PRESC_W-1:0]  presc;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_LEDS-1:0]   ch_led;
  logic [N_LEDS-1:0]   leds_next;
  logic [N_LEDS-1:0]   leds_reset;
  logic [31:0]         rdata_next;
  logic                wr_en;
  logic                rd_en;
  logic                unused_wdata;

  assign wr_en = i_sel & i_wr;
  assign rd_en = i_sel & i_rd;

  // Upper write-data bits beyond each register's width are discarded.
  assign unused_wdata = ^i_wdata;

`ifdef LEDS_ACTIVE_LOW_EN
  assign leds_next  = ~ch_led;
  assign leds_reset = '1;
`else
  assign leds_next  = ch_led;
  assign leds_reset = '0;
`endif

  // Register file writes; STATUS and unmapped offsets are silently dropped.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      led_en       <= '0;
      mode         <= '0;
      blink_period <= '0;
      for (int i = 0; i < N_LEDS; i++) duty[i] <= '0;
    end else if (wr_en) begin
      case (i_addr)
        OFS_LED_EN: led_en       <= i_wdata[N_LEDS-1:0];
        OFS_MODE:   mode         <= i_wdata[2*N_LEDS-1:0];
        OFS_BLINK:  blink_period <= i_wdata[PRESC_W-1:0];
        default:    ;
      endcase
      for (int i = 0; i < N_LEDS; i++) begin
        if (i_addr == 5'(OFS_DUTY0 + i)) duty[i] <= i_wdata[PWM_BITS-1:0];
      end
    end
  end

  // Blink prescaler: a period write restarts the count in the on phase.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      presc       <= '0;
      blink_phase <= 1'b1;
    end else if (wr_en && (i_addr == OFS_BLINK)) begin
      presc       <= i_wdata[PRESC_W-1:0];
      blink_phase <= 1'b1;
    end else if (presc == '0) begin
      presc       <= blink_period;
      blink_phase <= ~blink_phase;
    end else begin
      presc <= presc - PRESC_W'(1);
    end
  end

  // Free-running PWM counter shared by all channels.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Read mux over current register values, zero-extended.
  always_comb begin
    rdata_next = '0;
    case (i_addr)
      OFS_LED_EN: rdata_next = 32'(led_en);
      OFS_MODE:   rdata_next = 32'(mode);
      OFS_BLINK:  rdata_next = 32'(blink_period);
      OFS_STATUS: begin
        rdata_next[0]               = blink_phase;
        rdata_next[PWM_BITS+15:16] = pwm_cnt;
      end
      default:    ;
    endcase
    for (int i = 0; i < N_LEDS; i++) begin
      if (i_addr == 5'(OFS_DUTY0 + i)) rdata_next = 32'(duty[i]);
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)    o_rdata <= '0;
    else if (rd_en) o_rdata <= rdata_next;
  end

  // Registered LED drive.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) o_leds <= leds_reset;
    else         o_leds <= leds_next;
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
    io_led_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .en         (led_en[g]),
      .mode       (mode[2*g +: 2]),
      .duty       (duty[g]),
      .pwm_cnt    (pwm_cnt),
      .blink_phase(blink_phase),
      .led        (ch_led[g])
    );
  end

endmodule

// File: tb/tb_io_led_pwm_ctrl.sv
// Self-checking bench for io_led_pwm_ctrl: register table with read-back,
// static/blink/PWM sequences, bus corner cases and asynchronous reset.
// Honours LEDS_ACTIVE_LOW_EN when the design is built with it.
`timescale 1ns/1ps
module tb_io_led_pwm_ctrl;

  localparam int N_LEDS   = 8;
  localparam int PWM_BITS = 8;
  localparam int PRESC_W  = 24;

  logic              i_clk = 1'b0;
  logic              i_nrst;
  logic              i_sel;
  logic [4:0]        i_addr;
  logic              i_wr;
  logic              i_rd;
  logic [31:0]       i_wdata;
  logic [31:0]       o_rdata;
  logic [N_LEDS-1:0] o_leds;

  io_led_pwm_ctrl #(
    .N_LEDS  (N_LEDS),
    .PWM_BITS(PWM_BITS),
    .PRESC_W (PRESC_W)
  ) dut (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_sel  (i_sel),
    .i_addr (i_addr),
    .i_wr   (i_wr),
    .i_rd   (i_rd),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_leds (o_leds)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[9];

  // Reference register state, updated as the bench writes.
  logic [7:0]  sh_en;
  logic [15:0] sh_mode;
  logic [23:0] sh_blink;
  logic [7:0]  sh_duty [8];

  function automatic logic [N_LEDS-1:0] led_exp(input logic [N_LEDS-1:0] on);
`ifdef LEDS_ACTIVE_LOW_EN
    return ~on;
`else
    return on;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    int idx;
    idx = int'(addr) - 4;
    case (addr)
      5'd0:    return {24'd0, sh_en};
      5'd1:    return {16'd0, sh_mode};
      5'd2:    return {8'd0, sh_blink};
      default: begin
        if (idx >= 0 && idx < 8) return {24'd0, sh_duty[idx]};
        return 32'd0;
      end
    endcase
  endfunction

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data);
    int idx;
    idx = int'(addr) - 4;
    case (addr)
      5'd0: sh_en    = data[7:0];
      5'd1: sh_mode  = data[15:0];
      5'd2: sh_blink = data[23:0];
      default: if (idx >= 0 && idx < 8) sh_duty[idx] = data[7:0];
    endcase
  endtask

  task automatic model_reset();
    sh_en = '0; sh_mode = '0; sh_blink = '0;
    for (int i = 0; i < 8; i++) sh_duty[i] = '0;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      e = sb_q.pop_front();
      check_output(e.name, o_rdata, e.exp);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] addr, input logic [31:0] data);
    @(negedge i_clk);
    i_sel = 1'b1; i_wr = 1'b1; i_addr = addr; i_wdata = data;
    model_write(addr, data);
    @(negedge i_clk);
    i_sel = 1'b0; i_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
    @(negedge i_clk);
    i_sel = 1'b1; i_rd = 1'b1; i_addr = addr;
    sb_q.push_back('{name: name, exp: exp});
    @(negedge i_clk);
    i_sel = 1'b0; i_rd = 1'b0;
    pop_check();
  endtask

  task automatic pwm_count(input logic [31:0] duty, input int exp_high, input string name);
    int high;
    logic [N_LEDS-1:0] v;
    apply_stimulus(5'd4, duty);
    @(negedge i_clk);
    high = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge i_clk);
      v = led_exp(o_leds);
      if (v[0]) high++;
    end
    check_output(name, 32'(high), 32'(exp_high));
  endtask

  initial begin
    logic [N_LEDS-1:0] exp_leds;

    vecs[0] = '{addr: 5'd0,  wdata: 32'hFFFF_FFFF, exp: 32'h0000_00FF, name: "en_mask"};
    vecs[1] = '{addr: 5'd1,  wdata: 32'hFFFF_FFFF, exp: 32'h0000_FFFF, name: "mode_mask"};
    vecs[2] = '{addr: 5'd2,  wdata: 32'hFFFF_FFFF, exp: 32'h00FF_FFFF, name: "blink_mask"};
    vecs[3] = '{addr: 5'd4,  wdata: 32'h0000_01FF, exp: 32'h0000_00FF, name: "duty0_mask"};
    vecs[4] = '{addr: 5'd11, wdata: 32'h0000_ABCD, exp: 32'h0000_00CD, name: "duty7"};
    vecs[5] = '{addr: 5'd5,  wdata: 32'h0000_0012, exp: 32'h0000_0012, name: "duty1"};
    vecs[6] = '{addr: 5'd31, wdata: 32'hFFFF_FFFF, exp: 32'h0000_0000, name: "unmapped31"};
    vecs[7] = '{addr: 5'd12, wdata: 32'h0000_00FF, exp: 32'h0000_0000, name: "unmapped12"};
    vecs[8] = '{addr: 5'd20, wdata: 32'h0000_1234, exp: 32'h0000_0000, name: "unmapped20"};

    i_sel = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_addr = '0; i_wdata = '0;
    model_reset();
    i_nrst = 1'b1;
    #1 i_nrst = 1'b0;
    #1;
    check_output("reset_leds", 32'(o_leds), 32'(led_exp('0)));
    check_output("reset_rdata", o_rdata, 32'd0);
    repeat (3) @(negedge i_clk);
    check_output("reset_leds_hold", 32'(o_leds), 32'(led_exp('0)));
    i_nrst = 1'b1;

    $display("[TB] register table");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    apply_stimulus(5'd3, 32'hFFFF_FFFF);
    apply_stimulus(5'd31, 32'h5555_5555);
    for (int a = 0; a < 12; a++) begin
      if (a != 3) bus_read(5'(a), model_read(5'(a)), "no_change_sweep");
    end

    $display("[TB] static");
    apply_stimulus(5'd1, 32'd0);
    apply_stimulus(5'd0, 32'd0);
    @(negedge i_clk);
    check_output("static_pre", 32'(o_leds), 32'(led_exp('0)));
    apply_stimulus(5'd0, 32'h0000_00A5);
    check_output("static_1edge", 32'(o_leds), 32'(led_exp('0)));
    @(negedge i_clk);
    check_output("static_2edge", 32'(o_leds), 32'(led_exp(8'hA5)));
    bus_read(5'd0, 32'h0000_00A5, "static_readback");

    $display("[TB] blink");
    apply_stimulus(5'd0, 32'h1);
    apply_stimulus(5'd1, 32'h1);
    apply_stimulus(5'd2, 32'd3);
    for (int k = 2; k < 18; k++) begin
      @(negedge i_clk);
      exp_leds = (((k - 2) / 4) % 2 == 0) ? 8'h01 : 8'h00;
      check_output("blink_p3", 32'(o_leds), 32'(led_exp(exp_leds)));
    end
    apply_stimulus(5'd2, 32'd0);
    for (int k = 2; k < 10; k++) begin
      @(negedge i_clk);
      exp_leds = ((k - 2) % 2 == 0) ? 8'h01 : 8'h00;
      check_output("blink_p0", 32'(o_leds), 32'(led_exp(exp_leds)));
    end

    $display("[TB] pwm");
    apply_stimulus(5'd1, 32'h2);
    pwm_count(32'd64, 64, "pwm_duty64");
    pwm_count(32'd0, 0, "pwm_duty0");
    pwm_count(32'd255, 256, "pwm_duty255");
    pwm_count(32'd1, 1, "pwm_duty1");

    $display("[TB] bus corners");
    apply_stimulus(5'd4, 32'h33);
    @(negedge i_clk);
    i_sel = 1'b1; i_wr = 1'b1; i_rd = 1'b1; i_addr = 5'd4; i_wdata = 32'h77;
    sb_q.push_back('{name: "rw_same_old", exp: 32'h33});
    model_write(5'd4, 32'h77);
    @(negedge i_clk);
    i_sel = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
    pop_check();
    bus_read(5'd4, 32'h77, "rw_same_new");
    repeat (3) @(negedge i_clk);
    check_output("rdata_hold", o_rdata, 32'h77);

    $display("[TB] reset mid-blink");
    apply_stimulus(5'd0, 32'hFF);
    apply_stimulus(5'd1, 32'h1);
    apply_stimulus(5'd2, 32'd0);
    repeat (3) @(negedge i_clk);
    bus_read(5'd0, 32'hFF, "pre_reset_read");
    @(negedge i_clk);
    #2 i_nrst = 1'b0;
    model_reset();
    #1;
    check_output("midrst_leds", 32'(o_leds), 32'(led_exp('0)));
    check_output("midrst_rdata", o_rdata, 32'd0);
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
    i_sel = 1'b1; i_rd = 1'b1; i_addr = 5'd3;
    sb_q.push_back('{name: "status_after_reset", exp: 32'h0000_0001});
    @(negedge i_clk);
    i_sel = 1'b0; i_rd = 1'b0;
    pop_check();
    for (int a = 0; a < 12; a++) begin
      if (a != 3) bus_read(5'(a), model_read(5'(a)), "regs_after_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
